// File: rtl/tcp_vlg_tx_sched_if.sv
`default_nettype none
// ---- tcp_vlg_tx_sched_if : control/handshake bundle between rx/tx_ctl, scheduler and tx arbiter ---- rev 1.0
interface tcp_vlg_tx_sched_if #(
  parameter int KA_PROBES = 3
);
  localparam int c_PROBE_W = $clog2(KA_PROBES + 1);

  logic                 connected;
  logic                 rx_pkt;
  logic [31:0]          loc_ack;
  logic [31:0]          last_ack;
  logic                 ack_sent;
  logic                 pld_sent;
  logic                 ka_sent;
  logic                 send_ack;
  logic                 send_ka;
  logic [c_PROBE_W-1:0] ka_probes;
  logic                 ka_dead;

  modport master (
    output connected, rx_pkt, loc_ack, last_ack, ack_sent, pld_sent, ka_sent,
    input  send_ack, send_ka, ka_probes, ka_dead
  );

  modport slave (
    input  connected, rx_pkt, loc_ack, last_ack, ack_sent, pld_sent, ka_sent,
    output send_ack, send_ka, ka_probes, ka_dead
  );
endinterface
`default_nettype wire

// File: rtl/tcp_vlg_tx_sched.sv
`default_nettype none
// ---- tcp_vlg_tx_sched : delayed-ACK and keep-alive request scheduler for the TCP tx arbiter ---- rev 1.0
module tcp_vlg_tx_sched #(
  parameter int ACK_DELAY_TICKS   = 200,
  parameter int ACK_BYTES_THR     = 2920,
  parameter int KA_IDLE_TICKS     = 1000000,
  parameter int KA_INTERVAL_TICKS = 100000,
  parameter int KA_PROBES         = 3,
  parameter int TMR_W             = 32
) (
  input  wire logic        clk,
  input  wire logic        rst,
  tcp_vlg_tx_sched_if.slave bus
);
  localparam int                   c_PROBE_W   = $clog2(KA_PROBES + 1);
  localparam logic [TMR_W-1:0]     c_ACK_LAST  = TMR_W'(ACK_DELAY_TICKS - 1);
  localparam logic [TMR_W-1:0]     c_IDLE_LAST = TMR_W'(KA_IDLE_TICKS - 1);
  localparam logic [TMR_W-1:0]     c_INT_LAST  = TMR_W'(KA_INTERVAL_TICKS - 1);
  localparam logic [31:0]          c_ACK_THR   = 32'(ACK_BYTES_THR);
  localparam logic [c_PROBE_W-1:0] c_PROBES    = c_PROBE_W'(KA_PROBES);

  typedef enum logic [1:0] {
    KA_IDLE = 2'd0,
    KA_REQ  = 2'd1,
    KA_WAIT = 2'd2,
    KA_DEAD = 2'd3
  } ka_state_t;

  logic                 w_clr;
  logic                 w_pend;
  logic [31:0]          w_diff;
  logic                 w_ack_done;
  logic                 w_ack_fire;
  logic                 r_send_ack;
  logic [TMR_W-1:0]     r_ack_tmr;

  ka_state_t            r_ka_state;
  ka_state_t            w_ka_nxt;
  logic [c_PROBE_W-1:0] r_ka_probes;
  logic [c_PROBE_W-1:0] w_probes_nxt;
  logic [TMR_W-1:0]     r_idle_tmr;
  logic [TMR_W-1:0]     r_int_tmr;
  logic                 r_send_ka;
  logic                 r_ka_dead;

  // Dropping the connection behaves exactly like reset, every cycle it is low.
  assign w_clr      = rst | ~bus.connected;
  assign w_pend     = (bus.loc_ack != bus.last_ack);
  assign w_diff     = bus.loc_ack - bus.last_ack;
  assign w_ack_done = r_send_ack & (bus.ack_sent | bus.pld_sent);
  // A payload leaving this cycle already carries the ACK, so no forced ACK is raised.
  assign w_ack_fire = w_pend & ~r_send_ack & ~bus.pld_sent &
                      ((r_ack_tmr == c_ACK_LAST) | (w_diff >= c_ACK_THR));

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_send_ack <= 1'b0;
      r_ack_tmr  <= '0;
    end else begin
      if (w_ack_done)
        r_send_ack <= 1'b0;
      else if (w_ack_fire)
        r_send_ack <= 1'b1;

      if (!w_pend || w_ack_done || bus.pld_sent)
        r_ack_tmr <= '0;
      else if (!r_send_ack && (r_ack_tmr != c_ACK_LAST))
        r_ack_tmr <= r_ack_tmr + 1'b1;
    end
  end

  always_comb begin
    w_ka_nxt     = r_ka_state;
    w_probes_nxt = r_ka_probes;
    case (r_ka_state)
      KA_IDLE: if (r_idle_tmr == c_IDLE_LAST) w_ka_nxt = KA_REQ;
      KA_REQ: begin
        if (bus.ka_sent) begin
          w_ka_nxt     = KA_WAIT;
          w_probes_nxt = r_ka_probes + c_PROBE_W'(1);
        end
      end
      KA_WAIT: begin
        if (r_int_tmr == c_INT_LAST)
          w_ka_nxt = (r_ka_probes == c_PROBES) ? KA_DEAD : KA_REQ;
      end
      KA_DEAD: w_ka_nxt = KA_DEAD;
      default: w_ka_nxt = KA_IDLE;
    endcase
    // Any peer traffic proves liveness and overrides a coincident ka_sent; dead is sticky.
    if (bus.rx_pkt && (r_ka_state != KA_DEAD)) begin
      w_ka_nxt     = KA_IDLE;
      w_probes_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_ka_state  <= KA_IDLE;
      r_ka_probes <= '0;
      r_idle_tmr  <= '0;
      r_int_tmr   <= '0;
      r_send_ka   <= 1'b0;
      r_ka_dead   <= 1'b0;
    end else begin
      r_ka_state  <= w_ka_nxt;
      r_ka_probes <= w_probes_nxt;
      r_send_ka   <= (w_ka_nxt == KA_REQ);
      r_ka_dead   <= (w_ka_nxt == KA_DEAD);

      if (bus.rx_pkt)
        r_idle_tmr <= '0;
      else if (r_idle_tmr != c_IDLE_LAST)
        r_idle_tmr <= r_idle_tmr + 1'b1;

      // Interval timer starts from 0 on each entry to KA_WAIT.
      if ((r_ka_state == KA_WAIT) && (w_ka_nxt == KA_WAIT) && (r_int_tmr != c_INT_LAST))
        r_int_tmr <= r_int_tmr + 1'b1;
      else if ((r_ka_state != KA_WAIT) || (w_ka_nxt != KA_WAIT))
        r_int_tmr <= '0;
    end
  end

  assign bus.send_ack  = r_send_ack;
  assign bus.send_ka   = r_send_ka;
  assign bus.ka_probes = r_ka_probes;
  assign bus.ka_dead   = r_ka_dead;
endmodule
`default_nettype wire

// File: tb/tb_tcp_vlg_tx_sched.sv
`default_nettype none
// ---- tb_tcp_vlg_tx_sched : directed bench for the delayed-ACK / keep-alive scheduler ---- rev 1.0
module tb_tcp_vlg_tx_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  tcp_vlg_tx_sched_if #(.KA_PROBES(3)) bus ();

  tcp_vlg_tx_sched #(
    .ACK_DELAY_TICKS(8), .ACK_BYTES_THR(100), .KA_IDLE_TICKS(20),
    .KA_INTERVAL_TICKS(10), .KA_PROBES(3), .TMR_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // One cycle of !connected, then cycle 0 starts with connected=1 and the given acks.
  task automatic restart(input logic [31:0] loc, input logic [31:0] last);
    bus.connected = 1'b0;
    bus.rx_pkt = 1'b0; bus.ack_sent = 1'b0; bus.pld_sent = 1'b0; bus.ka_sent = 1'b0;
    tick();
    bus.connected = 1'b1;
    bus.loc_ack   = loc;
    bus.last_ack  = last;
    cyc = 0;
  endtask

  task automatic test_reset();
    bus.connected = 1'b1; bus.rx_pkt = 1'b0; bus.ack_sent = 1'b0; bus.pld_sent = 1'b0;
    bus.ka_sent = 1'b0; bus.loc_ack = 32'd50; bus.last_ack = 32'd0;
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({bus.send_ack, bus.send_ka, bus.ka_dead, bus.ka_probes} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 00000",
                         {bus.send_ack, bus.send_ka, bus.ka_dead, bus.ka_probes});
    end
    rst = 1'b0;
  endtask

  task automatic test_timeout_ack();
    restart(32'd1010, 32'd1000);
    run_to(7);
    n_checks++;
    if (bus.send_ack !== 1'b0) begin n_fail++; $display("FAIL timeout_early: send_ack got %b expected 0 at cycle 7", bus.send_ack); end
    run_to(8);
    n_checks++;
    if (bus.send_ack !== 1'b1) begin n_fail++; $display("FAIL timeout_fire: send_ack got %b expected 1 at cycle 8", bus.send_ack); end
    run_to(12);
    n_checks++;
    if (bus.send_ack !== 1'b1) begin n_fail++; $display("FAIL timeout_hold: send_ack got %b expected 1 at cycle 12", bus.send_ack); end
    bus.ack_sent = 1'b1; bus.last_ack = 32'd1010;
    tick();
    bus.ack_sent = 1'b0;
    n_checks++;
    if (bus.send_ack !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: send_ack got %b expected 0 at cycle 13", bus.send_ack); end
    // Pend again at cycle 13: a cleared timer needs the full 8 cycles.
    bus.loc_ack = 32'd1020;
    run_to(20);
    n_checks++;
    if (bus.send_ack !== 1'b0) begin n_fail++; $display("FAIL timeout_restart_early: send_ack got %b expected 0 at cycle 20", bus.send_ack); end
    run_to(21);
    n_checks++;
    if (bus.send_ack !== 1'b1) begin n_fail++; $display("FAIL timeout_restart: send_ack got %b expected 1 at cycle 21", bus.send_ack); end
  endtask

  task automatic test_threshold_wrap();
    restart(32'h0000_0030, 32'hFFFF_FFC0);
    n_checks++;
    if (bus.send_ack !== 1'b0) begin n_fail++; $display("FAIL wrap_c0: send_ack got %b expected 0", bus.send_ack); end
    tick();
    n_checks++;
    if (bus.send_ack !== 1'b1) begin n_fail++; $display("FAIL wrap_fire: send_ack got %b expected 1", bus.send_ack); end
    bus.pld_sent = 1'b1; bus.last_ack = 32'h0000_0030;
    tick();
    bus.pld_sent = 1'b0;
    n_checks++;
    if (bus.send_ack !== 1'b0) begin n_fail++; $display("FAIL wrap_pld_clear: send_ack got %b expected 0", bus.send_ack); end
    // Boundary: diff 99 stays quiet, diff 100 fires next cycle.
    restart(32'd1099, 32'd1000);
    tick();
    n_checks++;
    if (bus.send_ack !== 1'b0) begin n_fail++; $display("FAIL thr_99: send_ack got %b expected 0", bus.send_ack); end
    bus.loc_ack = 32'd1100;
    tick();
    n_checks++;
    if (bus.send_ack !== 1'b1) begin n_fail++; $display("FAIL thr_100: send_ack got %b expected 1", bus.send_ack); end
  endtask

  task automatic test_piggyback();
    restart(32'd510, 32'd500);
    run_to(4);
    bus.pld_sent = 1'b1;
    tick();
    bus.pld_sent = 1'b0;
    run_to(12);
    n_checks++;
    if (bus.send_ack !== 1'b0) begin n_fail++; $display("FAIL piggy_early: send_ack got %b expected 0 at cycle 12", bus.send_ack); end
    run_to(13);
    n_checks++;
    if (bus.send_ack !== 1'b1) begin n_fail++; $display("FAIL piggy_fire: send_ack got %b expected 1 at cycle 13", bus.send_ack); end
  endtask

  task automatic test_keepalive();
    restart(32'd0, 32'd0);
    run_to(19);
    n_checks++;
    if (bus.send_ka !== 1'b0) begin n_fail++; $display("FAIL ka_early: send_ka got %b expected 0 at cycle 19", bus.send_ka); end
    run_to(20);
    n_checks++;
    if (bus.send_ka !== 1'b1) begin n_fail++; $display("FAIL ka_fire: send_ka got %b expected 1 at cycle 20", bus.send_ka); end
    bus.ka_sent = 1'b1;
    tick();
    bus.ka_sent = 1'b0;
    n_checks++;
    if ({bus.send_ka, bus.ka_probes} !== 3'b0_01) begin n_fail++; $display("FAIL ka_sent: {send_ka,probes} got %b expected 001", {bus.send_ka, bus.ka_probes}); end
    run_to(25);
    bus.rx_pkt = 1'b1;
    tick();
    bus.rx_pkt = 1'b0;
    n_checks++;
    if (bus.ka_probes !== 2'd0) begin n_fail++; $display("FAIL ka_rx_clear: ka_probes got %0d expected 0", bus.ka_probes); end
    run_to(45);
    n_checks++;
    if (bus.send_ka !== 1'b0) begin n_fail++; $display("FAIL ka_rx_quiet: send_ka got %b expected 0 at cycle 45", bus.send_ka); end
    run_to(46);
    n_checks++;
    if (bus.send_ka !== 1'b1) begin n_fail++; $display("FAIL ka_rx_refire: send_ka got %b expected 1 at cycle 46", bus.send_ka); end
  endtask

  task automatic test_dead_peer();
    int exp_rise [3] = '{20, 33, 46};
    int idx     = 0;
    int sent_at = -1;
    logic prev_ka = 1'b0;
    restart(32'd0, 32'd0);
    while (cyc < 59) begin
      if (bus.send_ka && !prev_ka) begin
        n_checks++;
        if (idx > 2 || cyc != exp_rise[idx]) begin
          n_fail++; $display("FAIL dead_probe_time: probe %0d rose at cycle %0d expected %0d", idx, cyc, (idx > 2) ? -1 : exp_rise[idx]);
        end
        sent_at = cyc + 2;
        if (idx < 3) idx++;
      end
      if (cyc == 58) begin
        n_checks++;
        if (bus.ka_dead !== 1'b0) begin n_fail++; $display("FAIL dead_early: ka_dead got %b expected 0 at cycle 58", bus.ka_dead); end
      end
      prev_ka = bus.send_ka;
      bus.ka_sent = (cyc == sent_at);
      tick();
      bus.ka_sent = 1'b0;
    end
    n_checks++;
    if ({bus.ka_dead, bus.send_ka, bus.ka_probes} !== 4'b10_11) begin
      n_fail++; $display("FAIL dead_fire: {dead,send_ka,probes} got %b expected 1011", {bus.ka_dead, bus.send_ka, bus.ka_probes});
    end
    bus.rx_pkt = 1'b1;
    tick();
    bus.rx_pkt = 1'b0;
    tick();
    n_checks++;
    if (bus.ka_dead !== 1'b1) begin n_fail++; $display("FAIL dead_sticky: ka_dead got %b expected 1", bus.ka_dead); end
    bus.connected = 1'b0;
    tick();
    bus.connected = 1'b1;
    n_checks++;
    if ({bus.ka_dead, bus.ka_probes} !== 3'b0_00) begin n_fail++; $display("FAIL dead_drop: {dead,probes} got %b expected 000", {bus.ka_dead, bus.ka_probes}); end
  endtask

  task automatic test_collision();
    restart(32'd0, 32'd0);
    run_to(20);
    bus.ka_sent = 1'b1; bus.rx_pkt = 1'b1;
    tick();
    bus.ka_sent = 1'b0; bus.rx_pkt = 1'b0;
    n_checks++;
    if ({bus.send_ka, bus.ka_probes} !== 3'b0_00) begin n_fail++; $display("FAIL coll_rx_wins: {send_ka,probes} got %b expected 000", {bus.send_ka, bus.ka_probes}); end
    run_to(40);
    n_checks++;
    if (bus.send_ka !== 1'b0) begin n_fail++; $display("FAIL coll_idle: send_ka got %b expected 0 at cycle 40", bus.send_ka); end
    run_to(41);
    n_checks++;
    if (bus.send_ka !== 1'b1) begin n_fail++; $display("FAIL coll_refire: send_ka got %b expected 1 at cycle 41", bus.send_ka); end
    restart(32'd300, 32'd100);
    run_to(20);
    n_checks++;
    if ({bus.send_ack, bus.send_ka} !== 2'b11) begin n_fail++; $display("FAIL coll_both: {send_ack,send_ka} got %b expected 11", {bus.send_ack, bus.send_ka}); end
    bus.ka_sent = 1'b1;
    tick();
    bus.ka_sent = 1'b0;
    n_checks++;
    if ({bus.send_ack, bus.send_ka, bus.ka_probes} !== 4'b10_01) begin
      n_fail++; $display("FAIL coll_ka_only: {send_ack,send_ka,probes} got %b expected 1001", {bus.send_ack, bus.send_ka, bus.ka_probes});
    end
  endtask

  task automatic test_midop_drop();
    restart(32'd300, 32'd100);
    run_to(20);
    n_checks++;
    if ({bus.send_ack, bus.send_ka} !== 2'b11) begin n_fail++; $display("FAIL drop_pre: {send_ack,send_ka} got %b expected 11", {bus.send_ack, bus.send_ka}); end
    bus.connected = 1'b0;
    tick();
    bus.connected = 1'b1;
    bus.loc_ack = 32'd110;
    n_checks++;
    if ({bus.send_ack, bus.send_ka, bus.ka_probes} !== 4'b0) begin
      n_fail++; $display("FAIL drop_clear: {send_ack,send_ka,probes} got %b expected 0000", {bus.send_ack, bus.send_ka, bus.ka_probes});
    end
    run_to(28);
    n_checks++;
    if (bus.send_ack !== 1'b0) begin n_fail++; $display("FAIL drop_restart_early: send_ack got %b expected 0 at cycle 28", bus.send_ack); end
    run_to(29);
    n_checks++;
    if (bus.send_ack !== 1'b1) begin n_fail++; $display("FAIL drop_restart: send_ack got %b expected 1 at cycle 29", bus.send_ack); end
  endtask

  initial begin
    test_reset();
    test_timeout_ack();
    test_threshold_wrap();
    test_piggyback();
    test_keepalive();
    test_dead_peer();
    test_collision();
    test_midop_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
